mult_share_arbiter: RTL and testbench

Shares one pipelined unsigned WIDTH×WIDTH multiplier among NREQ requesters. Each requester presents operands under a valid/ready handshake. A round-robin arbiter grants at most one requester per cycle, and the operands plus a requester tag pass through a LAT-stage product pipeline. Each result returns on a single tagged response port. The block sits between the multiplier-consuming datapaths and the multiplier core, so one multiplier instance serves several clients at one operation per cycle.

---
 rtl/mult_share_arbiter_if.sv | 27 ++
 rtl/mult_share_arbiter.sv | 120 ++++++++++++
 tb/tb_mult_share_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_share_arbiter_if.sv
// rtl/mult_share_arbiter_if.sv - requester/response bundle for the shared multiplier
interface mult_share_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [2*WIDTH-1:0]    rsp_p;

  // Client side: presents operands, consumes tagged results.
  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_id, rsp_p
  );

  // Arbiter side: grants operands, returns tagged results.
  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_id, rsp_p
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin share of one pipelined unsigned multiplier
module mult_share_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int LAT   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  mult_share_arbiter_if.slave bus,
  output logic                busy
);
  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]     last;
  logic [NREQ-1:0]    grant;
  logic [IDW-1:0]     grant_id;
  logic               accept;
  logic [IDW-1:0]     idx;
  logic               found;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;

  logic [LAT-1:0]     vld;
  logic [IDW-1:0]     id_q [LAT];
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] p_out;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last) + k) % NREQ);
      if (en && !found && bus.req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        found      = 1'b1;
      end
    end
  end

  assign accept        = found;
  assign bus.req_ready = grant;

  // One-hot operand mux driven by the grant, so ungranted operands are never used.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        a_sel = bus.req_a[i*WIDTH +: WIDTH];
        b_sel = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer only moves on an accept; reset gives requester 0 first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= IDW'(NREQ - 1);
    end else if (accept) begin
      last <= grant_id;
    end
  end

  // Stage valid bits shift every cycle; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      vld[0] <= accept;
      for (int k = 1; k < LAT; k++) begin
        vld[k] <= vld[k-1];
      end
    end
  end

  // Tag and operand data registers, qualified only by the valid bits.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a_sel;
      b_q <= b_sel;
    end
    id_q[0] <= grant_id;
    for (int k = 1; k < LAT; k++) begin
      id_q[k] <= id_q[k-1];
    end
  end

  assign prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  generate
    if (LAT == 1) begin : g_lat1
      assign p_out = prod;
    end else begin : g_latn
      logic [2*WIDTH-1:0] p_q [1:LAT-1];

      // Product shift register for stages 2..LAT.
      always_ff @(posedge clk) begin
        p_q[1] <= prod;
        for (int k = 2; k < LAT; k++) begin
          p_q[k] <= p_q[k-1];
        end
      end

      assign p_out = p_q[LAT-1];
    end
  endgenerate

  // Outputs are forced to zero when no result is valid, giving clean reset values.
  assign bus.rsp_valid = vld[LAT-1];
  assign bus.rsp_id    = vld[LAT-1] ? id_q[LAT-1] : '0;
  assign bus.rsp_p     = vld[LAT-1] ? p_out : '0;
  assign busy          = |vld;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - directed self-checking bench for mult_share_arbiter
module tb_mult_share_arbiter;
  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int LAT   = 2;

  logic clk;
  logic rst_n;
  logic en;
  logic busy;
  int   n_checks;
  int   n_pass;
  logic [3:0] exp_rdy;

  mult_share_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  mult_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus.slave),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    rst_n         = 1'b0;
    en            = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;

    // reset state
    @(negedge clk); #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_id", 32'(bus.rsp_id), 0);
    check("rst_rsp_p", 32'(bus.rsp_p), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(bus.req_ready), 0);
    rst_n = 1'b1;

    // single op from requester 2
    @(negedge clk);
    set_op(2, 4'd13, 4'd11);
    bus.req_valid = 4'b0100;
    #1 check("single_ready", 32'(bus.req_ready), 32'b0100);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check("single_busy1", 32'(busy), 1);
    check("single_rv_early", 32'(bus.rsp_valid), 0);
    @(negedge clk); #1;
    check("single_rv", 32'(bus.rsp_valid), 1);
    check("single_id", 32'(bus.rsp_id), 2);
    check("single_p", 32'(bus.rsp_p), 143);
    check("single_busy2", 32'(busy), 1);
    @(negedge clk); #1;
    check("single_rv_end", 32'(bus.rsp_valid), 0);
    check("single_busy_end", 32'(busy), 0);

    // rotation with all requesters valid
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 4'(i + 1), 4'd3);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      exp_rdy = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
      #1;
      check($sformatf("rot_ready_%0d", c), 32'(bus.req_ready), 32'(exp_rdy));
      if (c >= 2) begin
        check($sformatf("rot_rv_%0d", c), 32'(bus.rsp_valid), 1);
        check($sformatf("rot_id_%0d", c), 32'(bus.rsp_id), 32'((c - 2) % 4));
        check($sformatf("rot_p_%0d", c), 32'(bus.rsp_p), 32'(3 * ((c - 2) % 4 + 1)));
      end
    end
    @(negedge clk); #1;
    check("rot_rv_end", 32'(bus.rsp_valid), 0);
    check("rot_busy_end", 32'(busy), 0);

    // pointer skip: grant 1, then 3,0,3 with 4'b1001
    @(negedge clk);
    bus.req_valid = 4'b0010;
    #1 check("skip_g1", 32'(bus.req_ready), 32'b0010);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.req_valid = 4'b1001;
      exp_rdy = (c == 1) ? 4'b0001 : 4'b1000;
      #1 check($sformatf("skip_%0d", c), 32'(bus.req_ready), 32'(exp_rdy));
    end
    @(negedge clk);
    bus.req_valid = '0;
    repeat (3) @(negedge clk);

    // max and zero operands, back to back
    @(negedge clk);
    set_op(0, 4'd15, 4'd15);
    bus.req_valid = 4'b0001;
    #1 check("max_g0", 32'(bus.req_ready), 32'b0001);
    @(negedge clk);
    set_op(1, 4'd0, 4'd15);
    bus.req_valid = 4'b0010;
    #1 check("max_g1", 32'(bus.req_ready), 32'b0010);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check("max_rv0", 32'(bus.rsp_valid), 1);
    check("max_id0", 32'(bus.rsp_id), 0);
    check("max_p0", 32'(bus.rsp_p), 225);
    @(negedge clk); #1;
    check("max_rv1", 32'(bus.rsp_valid), 1);
    check("max_id1", 32'(bus.rsp_id), 1);
    check("max_p1", 32'(bus.rsp_p), 0);
    @(negedge clk); #1;
    check("max_rv_end", 32'(bus.rsp_valid), 0);

    // enable: in-flight op drains while grants are blocked
    @(negedge clk);
    set_op(2, 4'd5, 4'd5);
    en = 1'b1;
    bus.req_valid = 4'b0100;
    #1 check("en_g2", 32'(bus.req_ready), 32'b0100);
    @(negedge clk);
    en = 1'b0;
    bus.req_valid = 4'b1111;
    #1;
    check("en_off_ready0", 32'(bus.req_ready), 0);
    check("en_off_rv0", 32'(bus.rsp_valid), 0);
    @(negedge clk); #1;
    check("en_off_ready1", 32'(bus.req_ready), 0);
    check("en_drain_rv", 32'(bus.rsp_valid), 1);
    check("en_drain_id", 32'(bus.rsp_id), 2);
    check("en_drain_p", 32'(bus.rsp_p), 25);
    @(negedge clk); #1;
    check("en_off_ready2", 32'(bus.req_ready), 0);
    check("en_off_rv2", 32'(bus.rsp_valid), 0);
    check("en_off_busy", 32'(busy), 0);
    @(negedge clk);
    en = 1'b1;
    #1 check("en_on_g3", 32'(bus.req_ready), 32'b1000);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (3) @(negedge clk);

    // reset mid-flight discards both ops
    @(negedge clk);
    set_op(0, 4'd7, 4'd9);
    set_op(1, 4'd2, 4'd2);
    bus.req_valid = 4'b0011;
    #1 check("mid_g0", 32'(bus.req_ready), 32'b0001);
    @(negedge clk); #1;
    check("mid_g1", 32'(bus.req_ready), 32'b0010);
    check("mid_busy", 32'(busy), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.req_valid = '0;
    @(negedge clk); #1;
    check("mid_rv", 32'(bus.rsp_valid), 0);
    check("mid_busy_clr", 32'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    bus.req_valid = 4'b1001;
    #1;
    check("mid_after_g0", 32'(bus.req_ready), 32'b0001);
    check("mid_after_rv", 32'(bus.rsp_valid), 0);
    @(negedge clk);
    bus.req_valid = '0;
    #1 check("mid_no_late_rsp", 32'(bus.rsp_valid), 0);
    @(negedge clk); #1;
    check("mid_new_rv", 32'(bus.rsp_valid), 1);
    check("mid_new_id", 32'(bus.rsp_id), 0);
    check("mid_new_p", 32'(bus.rsp_p), 63);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
